// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), coordinate type and a range helper.
package vga_timing_pkg;

  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC - 1;
  localparam int V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC - 1;

  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Raster outputs of the VGA timing generator; master drives, slave (display logic) consumes.
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   p_tick;
  logic   frame_tick;
  coord_t pix_x;
  coord_t pix_y;

  modport master (
    output hsync, vsync, video_on, p_tick, frame_tick, pix_x, pix_y
  );

  modport slave (
    input  hsync, vsync, video_on, p_tick, frame_tick, pix_x, pix_y
  );

endinterface

// File: rtl/vga_pix_tick.sv
// Pixel-rate divider: free-running 0..CLK_DIV-1 counter, p_tick on the last count.
module vga_pix_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_div_check
    $error("vga_pix_tick: CLK_DIV=%0d must be at least 2", CLK_DIV);
  end

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator: pixel/line counters with registered, zero-skew sync outputs.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t X_LAST     = coord_t'(H_TOT - 1);
  localparam coord_t Y_LAST     = coord_t'(V_TOT - 1);
  localparam coord_t X_VIS      = coord_t'(H_DISPLAY);
  localparam coord_t Y_VIS      = coord_t'(V_DISPLAY);
  localparam coord_t X_VIS_LAST = coord_t'(H_DISPLAY - 1);
  localparam coord_t Y_VIS_LAST = coord_t'(V_DISPLAY - 1);
  localparam coord_t HS_START   = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_END     = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_START   = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_END     = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  if (H_TOT > MAX_TOTAL || V_TOT > MAX_TOTAL) begin : g_range_check
    $error("vga_sync: H_TOTAL=%0d V_TOTAL=%0d exceed the 10-bit coordinate range", H_TOT, V_TOT);
  end

  logic   p_tick;
  logic   hsync_q;
  logic   vsync_q;
  coord_t x;
  coord_t y;
  coord_t next_x;
  coord_t next_y;

  vga_pix_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_pix_tick (
    .clk   (clk),
    .reset (reset),
    .p_tick(p_tick)
  );

  always_comb begin
    next_x = x;
    next_y = y;
    if (p_tick) begin
      if (x == X_LAST) begin
        next_x = '0;
        next_y = (y == Y_LAST) ? '0 : y + coord_t'(1);
      end else begin
        next_x = x + coord_t'(1);
      end
    end
  end

  // Syncs decode the next count so they switch on the same edge as pix_x/pix_y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x       <= next_x;
      y       <= next_y;
      hsync_q <= !in_range(next_x, HS_START, HS_END);
      vsync_q <= !in_range(next_y, VS_START, VS_END);
    end
  end

  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.p_tick     = p_tick;
  assign vga.pix_x      = x;
  assign vga.pix_y      = y;
  assign vga.video_on   = (x < X_VIS) && (y < Y_VIS);
  assign vga.frame_tick = p_tick && (x == X_VIS_LAST) && (y == Y_VIS_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync on a scaled-down raster so whole frames fit in a short run;
// expected behaviour is derived from the elapsed clock count since reset release.
module tb_vga_sync;

  localparam int CLK_DIV   = 4;
  localparam int H_DISPLAY = 40;
  localparam int H_FRONT   = 4;
  localparam int H_SYNC    = 8;
  localparam int H_BACK    = 6;
  localparam int V_DISPLAY = 12;
  localparam int V_FRONT   = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 4;

  localparam int H_TOT     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int LINE_CLK  = H_TOT * CLK_DIV;
  localparam int FRAME_CLK = LINE_CLK * V_TOT;
  localparam int HS_START  = H_DISPLAY + H_FRONT;
  localparam int HS_END    = HS_START + H_SYNC - 1;
  localparam int VS_START  = V_DISPLAY + V_FRONT;
  localparam int VS_END    = VS_START + V_SYNC - 1;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  int     checks   = 0;
  int     failures = 0;
  longint edges;

  vga_sync_if vga ();

  vga_sync #(
    .CLK_DIV  (CLK_DIV),
    .H_DISPLAY(H_DISPLAY),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_DISPLAY(V_DISPLAY),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vga  (vga)
  );

  always #5 clk = ~clk;

  // Elapsed clock edges since the last reset release: the whole model is a function of this.
  always @(posedge clk or posedge reset) begin
    if (reset) edges <= 0;
    else       edges <= edges + 1;
  end

  function automatic int exp_x(longint e);
    return int'((e / CLK_DIV) % H_TOT);
  endfunction

  function automatic int exp_y(longint e);
    return int'((e / CLK_DIV / H_TOT) % V_TOT);
  endfunction

  function automatic logic exp_ptick(longint e);
    return (e % CLK_DIV) == CLK_DIV - 1;
  endfunction

  task automatic do_reset(int hold);
    @(negedge clk);
    reset = 1'b1;
    repeat (hold) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (vga.pix_x !== 10'd0) begin failures++; $display("[TB] FAIL reset_pix_x actual=%0d expected=0", vga.pix_x); end
    checks++; if (vga.pix_y !== 10'd0) begin failures++; $display("[TB] FAIL reset_pix_y actual=%0d expected=0", vga.pix_y); end
    checks++; if (vga.hsync !== 1'b1) begin failures++; $display("[TB] FAIL reset_hsync actual=%b expected=1", vga.hsync); end
    checks++; if (vga.vsync !== 1'b1) begin failures++; $display("[TB] FAIL reset_vsync actual=%b expected=1", vga.vsync); end
    checks++; if (vga.p_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_p_tick actual=%b expected=0", vga.p_tick); end
    checks++; if (vga.frame_tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_tick actual=%b expected=0", vga.frame_tick); end
    checks++; if (vga.video_on !== 1'b1) begin failures++; $display("[TB] FAIL reset_video_on actual=%b expected=1", vga.video_on); end
  endtask

  task automatic test_release();
    do_reset(3);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (vga.p_tick !== ((k % CLK_DIV) == CLK_DIV - 1)) begin
        failures++; $display("[TB] FAIL release_p_tick cycle=%0d actual=%b expected=%b", k, vga.p_tick, (k % CLK_DIV) == CLK_DIV - 1);
      end
      if (k == CLK_DIV) begin
        checks++;
        if (vga.pix_x !== 10'd1) begin failures++; $display("[TB] FAIL release_pix_x actual=%0d expected=1", vga.pix_x); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_line();
    int   falls[$];
    int   low_run = 0;
    int   prev_x = 0;
    int   prev_y = 0;
    logic prev_hs = 1'b1;
    bit   wrap_seen = 0;
    do_reset(2);
    for (int c = 0; c < 3 * LINE_CLK; c++) begin
      @(negedge clk);
      if (prev_hs && !vga.hsync) begin
        falls.push_back(c);
        checks++;
        if (int'(vga.pix_x) != HS_START) begin failures++; $display("[TB] FAIL hsync_start_x actual=%0d expected=%0d", vga.pix_x, HS_START); end
      end
      if (!vga.hsync) low_run++;
      if (!prev_hs && vga.hsync) begin
        checks++;
        if (low_run != H_SYNC * CLK_DIV) begin failures++; $display("[TB] FAIL hsync_width actual=%0d expected=%0d", low_run, H_SYNC * CLK_DIV); end
        low_run = 0;
      end
      if (prev_x == H_TOT - 1 && vga.pix_x == 10'd0) begin
        wrap_seen = 1;
        checks++;
        if (int'(vga.pix_y) != (prev_y + 1) % V_TOT) begin failures++; $display("[TB] FAIL line_y_inc actual=%0d expected=%0d", vga.pix_y, (prev_y + 1) % V_TOT); end
      end
      prev_hs = vga.hsync;
      prev_x  = int'(vga.pix_x);
      prev_y  = int'(vga.pix_y);
    end
    checks++;
    if (falls.size() < 2) begin
      failures++; $display("[TB] FAIL line_period actual=%0d_falls expected=2_or_more", falls.size());
    end else if (falls[1] - falls[0] != LINE_CLK) begin
      failures++; $display("[TB] FAIL line_period actual=%0d expected=%0d", falls[1] - falls[0], LINE_CLK);
    end
    checks++;
    if (!wrap_seen) begin failures++; $display("[TB] FAIL line_wrap actual=none expected=x_wrap"); end
  endtask

  task automatic test_frame();
    int   falls[$];
    int   ticks_low = 0;
    int   prev_y = 0;
    logic prev_vs = 1'b1;
    bit   wrap_seen = 0;
    do_reset(2);
    for (int c = 0; c < 2 * FRAME_CLK + LINE_CLK; c++) begin
      @(negedge clk);
      if (prev_vs && !vga.vsync) begin
        falls.push_back(c);
        checks++;
        if (int'(vga.pix_y) != VS_START || vga.pix_x != 10'd0) begin
          failures++; $display("[TB] FAIL vsync_start actual=(%0d,%0d) expected=(0,%0d)", vga.pix_x, vga.pix_y, VS_START);
        end
      end
      if (!vga.vsync && vga.p_tick) ticks_low++;
      if (!prev_vs && vga.vsync) begin
        checks++;
        if (ticks_low != V_SYNC * H_TOT) begin failures++; $display("[TB] FAIL vsync_width actual=%0d expected=%0d", ticks_low, V_SYNC * H_TOT); end
        ticks_low = 0;
      end
      if (prev_y == V_TOT - 1 && vga.pix_y == 10'd0) begin
        wrap_seen = 1;
        checks++;
        if (vga.pix_x !== 10'd0) begin failures++; $display("[TB] FAIL frame_wrap_x actual=%0d expected=0", vga.pix_x); end
      end
      prev_vs = vga.vsync;
      prev_y  = int'(vga.pix_y);
    end
    checks++;
    if (falls.size() < 2) begin
      failures++; $display("[TB] FAIL frame_period actual=%0d_falls expected=2_or_more", falls.size());
    end else if (falls[1] - falls[0] != FRAME_CLK) begin
      failures++; $display("[TB] FAIL frame_period actual=%0d expected=%0d", falls[1] - falls[0], FRAME_CLK);
    end
    checks++;
    if (!wrap_seen) begin failures++; $display("[TB] FAIL frame_wrap actual=none expected=y_wrap"); end
  endtask

  task automatic test_video_on();
    int   vis_ticks = 0;
    int   prev_y = 0;
    logic prev_v = 1'b1;
    bit   top_seen = 0;
    do_reset(2);
    for (int c = 0; c < FRAME_CLK + LINE_CLK; c++) begin
      @(negedge clk);
      if (c < FRAME_CLK && vga.p_tick && vga.video_on) vis_ticks++;
      if (prev_v && !vga.video_on) begin
        checks++;
        if (int'(vga.pix_x) != H_DISPLAY) begin failures++; $display("[TB] FAIL video_fall_x actual=%0d expected=%0d", vga.pix_x, H_DISPLAY); end
      end
      if (!prev_v && vga.video_on) begin
        checks++;
        if (vga.pix_x !== 10'd0) begin failures++; $display("[TB] FAIL video_rise_x actual=%0d expected=0", vga.pix_x); end
      end
      if (vga.pix_x == 10'd0 && int'(vga.pix_y) == V_DISPLAY) begin
        checks++;
        if (vga.video_on !== 1'b0) begin failures++; $display("[TB] FAIL video_blank_y actual=%b expected=0", vga.video_on); end
      end
      if (prev_y == V_TOT - 1 && vga.pix_y == 10'd0) begin
        top_seen = 1;
        checks++;
        if (vga.video_on !== 1'b1) begin failures++; $display("[TB] FAIL video_origin actual=%b expected=1", vga.video_on); end
      end
      prev_v = vga.video_on;
      prev_y = int'(vga.pix_y);
    end
    checks++;
    if (vis_ticks != H_DISPLAY * V_DISPLAY) begin failures++; $display("[TB] FAIL video_tick_count actual=%0d expected=%0d", vis_ticks, H_DISPLAY * V_DISPLAY); end
    checks++;
    if (!top_seen) begin failures++; $display("[TB] FAIL video_origin_seen actual=none expected=frame_wrap"); end
  endtask

  task automatic test_frame_tick();
    int pulses = 0;
    int first_c = -1;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (vga.frame_tick !== 1'b0) begin failures++; $display("[TB] FAIL frame_tick_in_reset actual=%b expected=0", vga.frame_tick); end
    end
    reset = 1'b0;
    for (int c = 0; c < 2 * FRAME_CLK; c++) begin
      @(negedge clk);
      if (vga.frame_tick) begin
        pulses++;
        checks++;
        if (!vga.p_tick || int'(vga.pix_x) != H_DISPLAY - 1 || int'(vga.pix_y) != V_DISPLAY - 1) begin
          failures++; $display("[TB] FAIL frame_tick_pos actual=(%0d,%0d,p=%b) expected=(%0d,%0d,p=1)", vga.pix_x, vga.pix_y, vga.p_tick, H_DISPLAY - 1, V_DISPLAY - 1);
        end
        if (first_c < 0) begin
          first_c = c;
        end else begin
          checks++;
          if (c - first_c != FRAME_CLK) begin failures++; $display("[TB] FAIL frame_tick_period actual=%0d expected=%0d", c - first_c, FRAME_CLK); end
        end
      end
    end
    checks++;
    if (pulses != 2) begin failures++; $display("[TB] FAIL frame_tick_count actual=%0d expected=2", pulses); end
  endtask

  task automatic test_mid_frame_reset();
    localparam int TX = HS_START + 4;
    bit found = 0;
    do_reset(2);
    for (int c = 0; c < 2 * FRAME_CLK && !found; c++) begin
      @(negedge clk);
      if (int'(vga.pix_x) == TX && int'(vga.pix_y) == VS_START) found = 1;
    end
    checks++;
    if (!found) begin
      failures++; $display("[TB] FAIL midreset_reach actual=timeout expected=(%0d,%0d)", TX, VS_START);
      return;
    end
    checks++;
    if (vga.hsync !== 1'b0 || vga.vsync !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_syncs_low actual=%b%b expected=00", vga.hsync, vga.vsync);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (vga.hsync !== 1'b1 || vga.vsync !== 1'b1) begin failures++; $display("[TB] FAIL midreset_syncs actual=%b%b expected=11", vga.hsync, vga.vsync); end
    checks++;
    if (vga.pix_x !== 10'd0 || vga.pix_y !== 10'd0) begin failures++; $display("[TB] FAIL midreset_counts actual=(%0d,%0d) expected=(0,0)", vga.pix_x, vga.pix_y); end
    checks++;
    if (vga.p_tick !== 1'b0) begin failures++; $display("[TB] FAIL midreset_p_tick actual=%b expected=0", vga.p_tick); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2 * CLK_DIV; k++) begin
      checks++;
      if (vga.p_tick !== ((k % CLK_DIV) == CLK_DIV - 1)) begin
        failures++; $display("[TB] FAIL midreset_first_tick cycle=%0d actual=%b expected=%b", k, vga.p_tick, (k % CLK_DIV) == CLK_DIV - 1);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      int len;
      len = int'($urandom_range(100, FRAME_CLK + 200));
      do_reset(int'($urandom_range(1, 5)));
      for (int c = 0; c < len; c++) begin
        logic [24:0] act;
        logic [24:0] exp;
        int   ex;
        int   ey;
        logic ep;
        @(negedge clk);
        ex = exp_x(edges);
        ey = exp_y(edges);
        ep = exp_ptick(edges);
        exp = {10'(ex), 10'(ey), ep,
               !(ex >= HS_START && ex <= HS_END),
               !(ey >= VS_START && ey <= VS_END),
               (ex < H_DISPLAY) && (ey < V_DISPLAY),
               ep && ex == H_DISPLAY - 1 && ey == V_DISPLAY - 1};
        act = {vga.pix_x, vga.pix_y, vga.p_tick, vga.hsync, vga.vsync, vga.video_on, vga.frame_tick};
        checks++;
        if (act !== exp) begin
          failures++; $display("[TB] FAIL model_compare edge=%0d actual=%h expected=%h", edges, act, exp);
        end
        if ($urandom_range(0, 499) == 0) begin
          #($urandom_range(1, 3));
          reset = 1'b1;
          #1 reset = 1'b0;
        end
      end
    end
  endtask

  initial begin
    $display("[TB] vga_sync bench start");
    test_reset();
    test_release();
    test_line();
    test_frame();
    test_video_on();
    test_frame_tick();
    test_mid_frame_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: system clocks per pixel (100 MHz to 25 MHz).
REQ-002 The block SHALL have parameters H_DISPLAY=640, H_FRONT=16, H_SYNC=96, H_BACK=48: horizontal timing in pixels.
REQ-003 The block SHALL have parameters V_DISPLAY=480, V_FRONT=10, V_SYNC=2, V_BACK=33: vertical timing in lines.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port hsync, output, 1 bit: horizontal sync, active low, registered.
REQ-007 The block SHALL have port vsync, output, 1 bit: vertical sync, active low, registered.
REQ-008 The block SHALL have port video_on, output, 1 bit: high while the current pixel is in the visible area.
REQ-009 The block SHALL have port p_tick, output, 1 bit: one-clk pulse once per pixel period.
REQ-010 The block SHALL have port pix_x, output, 10 bits: current horizontal count, 0..H_TOTAL-1.
REQ-011 The block SHALL have port pix_y, output, 10 bits: current vertical count, 0..V_TOTAL-1.
REQ-012 The block SHALL have port frame_tick, output, 1 bit: one-clk pulse at the end of active video.

Function
REQ-013 H_TOTAL SHALL equal the sum of the four H parameters (800), and V_TOTAL SHALL equal the sum of the four V parameters (525).
REQ-014 The divider SHALL count 0..CLK_DIV-1, wrapping to 0, with width $clog2(CLK_DIV); p_tick SHALL be high exactly when the divider equals CLK_DIV-1.
REQ-015 pix_x SHALL increment by 1 on each clk edge where p_tick is high, and SHALL wrap from H_TOTAL-1 to 0.
REQ-016 pix_y SHALL increment only on the edge where p_tick is high and pix_x==H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0; an increment and a wrap in the same edge SHALL both take effect.
REQ-017 pix_x and pix_y SHALL hold their values on every edge where p_tick is low.
REQ-018 hsync SHALL be 0 iff pix_x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (656..751), and 1 otherwise.
REQ-019 vsync SHALL be 0 iff pix_y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (490..491), and 1 otherwise.
REQ-020 hsync and vsync SHALL be registered from the next-count values, so they are cycle-aligned with pix_x/pix_y with zero skew and are glitch-free.
REQ-021 video_on SHALL be combinational: (pix_x < H_DISPLAY) && (pix_y < V_DISPLAY).
REQ-022 frame_tick SHALL be combinational: p_tick && pix_x==H_DISPLAY-1 && pix_y==V_DISPLAY-1, giving exactly one pulse per frame.
REQ-023 Every parameter set SHALL satisfy H_TOTAL and V_TOTAL <= 1024; out-of-range totals SHALL be an elaboration error.

Reset
REQ-024 Asserting reset SHALL immediately clear the divider, pix_x and pix_y to 0, and set hsync and vsync to 1.
REQ-025 While reset is held, p_tick and frame_tick SHALL be 0, and video_on SHALL be 1 (the position is 0,0).
REQ-026 Reset asserted mid-frame SHALL abandon the frame; after release, the first p_tick SHALL occur on the CLK_DIV-th clk cycle.

Structure
REQ-027 Package vga_timing_pkg SHALL hold the default timing constants, H_TOTAL/V_TOTAL, the sync start/end constants and the 10-bit coordinate width.
REQ-028 The pixel divider SHALL be one sub-module, vga_pix_tick (parameter CLK_DIV; ports clk, reset, p_tick); the counters and sync logic SHALL stay in vga_sync.

Verification
REQ-029 The bench SHALL check release from reset: p_tick is high at clk cycles 3, 7, 11…; pix_x reads 1 after cycle 3.
REQ-030 The bench SHALL check the line: the hsync low pulse lasts 384 clk starting when pix_x=656; line period = 3200 clk; pix_y increments when pix_x wraps 799->0.
REQ-031 The bench SHALL check the frame: the vsync low pulse lasts 1600 pixel ticks (pix_y 490..491); the frame period is 1,680,000 clk; pix_y wraps 524->0.
REQ-032 The bench SHALL check video_on: it goes low at pix_x=640 and at pix_y=480, and high again at (0,0); 307,200 video_on pixel ticks occur per frame.
REQ-033 The bench SHALL check frame_tick: exactly one pulse per frame, coincident with p_tick at (639,479); none occur during reset.
REQ-034 The bench SHALL check reset at pix_x=700, pix_y=490: hsync, vsync go to 1, and counts go to 0, asynchronously, before the next clk edge.
